imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words and writes
// them to instruction RAM at consecutive word addresses while holding the CPU.
module imem_loader #(
  parameter int          WORD_COUNT = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_d     = data_q;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid) begin
          cnt_d   = cnt_q + 2'd1;
          shift_d = {shift_q[15:0], byte_data};
          if (cnt_q == 2'd3) begin
            // Earlier bytes sit higher in the shift register: big-endian word.
            data_d  = {shift_q, byte_data};
            addr_d  = BASE_ADDR + idx_q;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wr_en    = 1'b1;
        cpu_hold = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: three instances cover single-word,
// multi-word and address-wrap configurations against a queue-based write model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start, bvalid, ready, wr_en, hold, done;
  logic [7:0]  bdata [3];
  logic [15:0] waddr [3];
  logic [31:0] wdata [3];

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t wlog[$];
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 clk = ~clk;

  imem_loader #(.WORD_COUNT(1), .BASE_ADDR(16'h0000)) u_single (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .byte_valid(bvalid[0]),
    .byte_data(bdata[0]), .byte_ready(ready[0]), .wr_en(wr_en[0]),
    .wr_addr(waddr[0]), .wr_data(wdata[0]), .cpu_hold(hold[0]), .done(done[0]));

  imem_loader #(.WORD_COUNT(3), .BASE_ADDR(16'h0001)) u_multi (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .byte_valid(bvalid[1]),
    .byte_data(bdata[1]), .byte_ready(ready[1]), .wr_en(wr_en[1]),
    .wr_addr(waddr[1]), .wr_data(wdata[1]), .cpu_hold(hold[1]), .done(done[1]));

  imem_loader #(.WORD_COUNT(2), .BASE_ADDR(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .byte_valid(bvalid[2]),
    .byte_data(bdata[2]), .byte_ready(ready[2]), .wr_en(wr_en[2]),
    .wr_addr(waddr[2]), .wr_data(wdata[2]), .cpu_hold(hold[2]), .done(done[2]));

  // Write monitor: each strobe lasts one cycle, so one sample per strobe.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (wr_en[i] === 1'b1) wlog.push_back('{2'(i), waddr[i], wdata[i]});
  end

  function automatic logic [15:0] base_of(input int i);
    case (i)
      0:       return 16'h0000;
      1:       return 16'h0001;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input int i, input logic [7:0] b);
    int n = 0;
    bvalid[i] = 1'b1;
    bdata[i]  = b;
    while (ready[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(ready[i]), 64'd1);
    @(negedge clk);
    bvalid[i] = 1'b0;
    bdata[i]  = 8'($urandom);
  endtask

  task automatic idle_noise(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bvalid[i] = 1'($urandom_range(0, 1));
      bdata[i]  = 8'($urandom);
      @(negedge clk);
    end
    bvalid[i] = 1'b0;
  endtask

  // Full load of n words; poke drives garbage during WRITE and start mid-word.
  task automatic load(input int i, input int n, input logic [31:0] words [4],
                      input int max_gap, input bit poke);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    check("hold_after_start", 64'(hold[i]), 64'd1);
    check("done_after_start", 64'(done[i]), 64'd0);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{2'(i), 16'(base_of(i) + 16'(k)), words[k]});
      for (int j = 0; j < 4; j++) begin
        int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        if (poke && k == 1 && j == 2) begin
          start[i] = 1'b1;
          @(negedge clk);
          start[i] = 1'b0;
        end
        for (int g = 0; g < gap; g++) begin
          bvalid[i] = 1'b0;
          bdata[i]  = 8'($urandom);
          @(negedge clk);
        end
        send_byte(i, words[k][31 - 8*j -: 8]);
      end
      check("wr_en_write", 64'(wr_en[i]), 64'd1);
      check("ready_write", 64'(ready[i]), 64'd0);
      if (poke) begin
        bvalid[i] = 1'b1;
        bdata[i]  = 8'($urandom);
        @(negedge clk);
        bvalid[i] = 1'b0;
      end else if (k == n - 1) begin
        @(negedge clk);
      end
    end
    check("done_end", 64'(done[i]), 64'd1);
    check("hold_end", 64'(hold[i]), 64'd0);
    check("wr_en_end", 64'(wr_en[i]), 64'd0);
    check("data_hold", 64'(wdata[i]), 64'(words[n-1]));
  endtask

  task automatic verify_writes(input string tag);
    @(negedge clk);
    check({tag, "_count"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wlog.size(); k++)
      check({tag, "_write"}, 64'(wlog[k]), 64'(exp_q[k]));
    wlog.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w [4];
    rst_n  = 1'b0;
    start  = '0;
    bvalid = '0;
    for (int i = 0; i < 3; i++) bdata[i] = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 64'(ready[i]), 64'd0);
      check("rst_wr_en", 64'(wr_en[i]), 64'd0);
      check("rst_hold",  64'(hold[i]),  64'd0);
      check("rst_done",  64'(done[i]),  64'd0);
      check("rst_addr",  64'(waddr[i]), 64'(base_of(i)));
      check("rst_data",  64'(wdata[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, back-to-back bytes, then noise while DONE.
    w = '{32'hF8400081, 32'h0, 32'h0, 32'h0};
    load(0, 1, w, 0, 1'b0);
    idle_noise(0, 8);
    check("done_noise_ready", 64'(ready[0]), 64'd0);
    check("done_noise_done", 64'(done[0]), 64'd1);
    verify_writes("single");

    // Reload with fresh random bytes.
    w[0] = $urandom;
    load(0, 1, w, 2, 1'b0);
    verify_writes("reload");

    // Three words with gaps, noise in IDLE, stray start and WRITE-cycle pokes.
    idle_noise(1, 6);
    check("idle_ready", 64'(ready[1]), 64'd0);
    check("idle_hold", 64'(hold[1]), 64'd0);
    w = '{32'hF8400081, 32'hF8401082, 32'h8B020023, 32'h0};
    load(1, 3, w, 3, 1'b1);
    verify_writes("multi");

    // Address wrap from FFFF to 0000.
    w = '{$urandom, $urandom, 32'h0, 32'h0};
    load(2, 2, w, 1, 1'b0);
    verify_writes("wrap");

    // Asynchronous reset after two bytes of a word.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", 64'(ready[0]), 64'd0);
    check("async_hold",  64'(hold[0]),  64'd0);
    check("async_wr_en", 64'(wr_en[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = '{32'h11223344, 32'h0, 32'h0, 32'h0};
    load(0, 1, w, 0, 1'b0);
    verify_writes("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
